// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory-port arbiter:
// the owner-state encoding and the default RAM geometry.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 32;

    // Which requester was granted the RAM in the previous cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_IF = 2'd1,
        OWN_D  = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Fetch starvation counter: counts consecutive cycles in which fetch is
// stalled and raises force_fetch once the count reaches STARVE_MAX.
// Requires STARVE_MAX >= 1.
module arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clockCPU,
    input  logic reset,
    input  logic fetch_stall,
    input  logic fetch_clear,
    output logic force_fetch
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] count;

    // Count stalled fetch cycles; saturate at STARVE_MAX, clear on grant or idle fetch.
    always_ff @(posedge clockCPU) begin
        if (reset) begin
            count <= '0;
        end else if (fetch_clear) begin
            count <= '0;
        end else if (fetch_stall && (count != CW'(STARVE_MAX))) begin
            count <= count + 1'b1;
        end
    end

    // Fetch is forced to win once the limit is reached.
    always_comb begin
        force_fetch = (count == CW'(STARVE_MAX));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch and the
// data stage. Grant is combinational in cycle N; the registered owner
// steers mem_q to the right requester in cycle N+1.
// Optional macro ARB_STARVE_GUARD_EN adds a fetch starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clockCPU,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_stall,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    owner_e owner;
    owner_e owner_next;
    logic   owner_we;
    logic   owner_we_next;
    logic   grant_if;
    logic   grant_d;
    logic   starve_force;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clockCPU   (clockCPU),
        .reset      (reset),
        .fetch_stall(if_stall),
        .fetch_clear(grant_if | ~if_req),
        .force_fetch(starve_force)
    );
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX != 0);
    assign starve_force      = 1'b0;
`endif

    // Owner register and the write flag of the access in flight.
    always_ff @(posedge clockCPU) begin
        if (reset) begin
            owner    <= IDLE;
            owner_we <= 1'b0;
        end else begin
            owner    <= owner_next;
            owner_we <= owner_we_next;
        end
    end

    // Grant selection, RAM port steering, stalls and next owner.
    always_comb begin
        grant_if      = 1'b0;
        grant_d       = 1'b0;
        mem_addr      = '0;
        mem_data      = '0;
        mem_wren      = 1'b0;
        owner_next    = IDLE;
        owner_we_next = 1'b0;
        if (!reset) begin
            if (d_req && !(if_req && starve_force)) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
        if (grant_d) begin
            mem_addr      = d_addr;
            mem_data      = d_wdata;
            mem_wren      = d_we;
            owner_next    = OWN_D;
            owner_we_next = d_we;
        end else if (grant_if) begin
            mem_addr   = if_addr;
            owner_next = OWN_IF;
        end
        if_stall = if_req && !grant_if && !reset;
        d_stall  = d_req && !grant_d && !reset;
    end

    // Response steering; reset gates a response already in flight.
    always_comb begin
        if_valid = (owner == OWN_IF) && !reset;
        d_valid  = (owner == OWN_D) && !reset;
        if_rdata = '0;
        d_rdata  = '0;
        if (if_valid) begin
            if_rdata = mem_q;
        end
        if (d_valid && !owner_we) begin
            d_rdata = mem_q;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural one-cycle RAM.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        if_stall;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_stall;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    logic [31:0] ram [0:1023];

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .ADDR_W(10),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clockCPU(clk),
        .reset   (reset),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_stall(if_stall),
        .if_valid(if_valid),
        .if_rdata(if_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_stall (d_stall),
        .d_valid (d_valid),
        .d_rdata (d_rdata),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_wren(mem_wren),
        .mem_q   (mem_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM, registered read.
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs just after the edge; return mid-cycle for checks.
    task automatic drive(input logic ir, input logic [9:0] ia, input logic dr, input logic dw,
                         input logic [9:0] da, input logic [31:0] dwd, input logic rs);
        @(posedge clk);
        #1;
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dwd;
        reset   = rs;
        #3;
    endtask

    // Monitor: every response pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (if_valid || d_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {30'b0, if_valid, d_valid}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_kind", {31'b0, d_valid}, {31'b0, e.is_d});
                chk("resp_data", d_valid ? d_rdata : if_rdata, e.data);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[10'h004] = 32'h00A00093;
        ram[10'h010] = 32'hDEADBEEF;
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset with requests pending: nothing granted or stalled.
        drive(1'b1, 10'h004, 1'b1, 1'b1, 10'h020, 32'hFFFF0000, 1'b1);
        drive(1'b1, 10'h004, 1'b1, 1'b1, 10'h020, 32'hFFFF0000, 1'b1);
        chk("rst_if_stall", {31'b0, if_stall}, 32'h0);
        chk("rst_d_stall",  {31'b0, d_stall},  32'h0);
        chk("rst_wren",     {31'b0, mem_wren}, 32'h0);
        chk("rst_addr",     {22'b0, mem_addr}, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_d_valid",  {31'b0, d_valid},  32'h0);

        // Fetch only.
        drive(1'b1, 10'h004, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        chk("fetch_stall", {31'b0, if_stall}, 32'h0);
        chk("fetch_addr",  {22'b0, mem_addr}, 32'h004);
        chk("fetch_wren",  {31'b0, mem_wren}, 32'h0);
        push(1'b0, 32'h00A00093);

        // Simultaneous: data wins, fetch stalled.
        drive(1'b1, 10'h004, 1'b1, 1'b0, 10'h010, 32'h0, 1'b0);
        chk("both_if_stall", {31'b0, if_stall}, 32'h1);
        chk("both_d_stall",  {31'b0, d_stall},  32'h0);
        chk("both_addr",     {22'b0, mem_addr}, 32'h010);
        push(1'b1, 32'hDEADBEEF);

        // Data drops: held fetch now granted.
        drive(1'b1, 10'h004, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        chk("refetch_stall", {31'b0, if_stall}, 32'h0);
        chk("refetch_addr",  {22'b0, mem_addr}, 32'h004);
        push(1'b0, 32'h00A00093);

        // Write.
        drive(1'b0, 10'h000, 1'b1, 1'b1, 10'h020, 32'h12345678, 1'b0);
        chk("wr_wren", {31'b0, mem_wren}, 32'h1);
        chk("wr_addr", {22'b0, mem_addr}, 32'h020);
        chk("wr_data", mem_data, 32'h12345678);
        push(1'b1, 32'h0);

        // Idle: port quiet.
        drive(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        chk("idle_addr",  {22'b0, mem_addr}, 32'h0);
        chk("idle_data",  mem_data, 32'h0);
        chk("idle_wren",  {31'b0, mem_wren}, 32'h0);
        chk("idle_stall", {30'b0, if_stall, d_stall}, 32'h0);

        // Read back the written word.
        drive(1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 32'h0, 1'b0);
        chk("rd_wren", {31'b0, mem_wren}, 32'h0);
        push(1'b1, 32'h12345678);

        // Sustained contention.
`ifdef ARB_STARVE_GUARD_EN
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 10'h004, 1'b1, 1'b0, 10'h010, 32'h0, 1'b0);
            chk("starve_if_stall", {31'b0, if_stall}, 32'h1);
            push(1'b1, 32'hDEADBEEF);
        end
        drive(1'b1, 10'h004, 1'b1, 1'b0, 10'h010, 32'h0, 1'b0);
        chk("forced_if_stall", {31'b0, if_stall}, 32'h0);
        chk("forced_d_stall",  {31'b0, d_stall},  32'h1);
        chk("forced_addr",     {22'b0, mem_addr}, 32'h004);
        push(1'b0, 32'h00A00093);
        drive(1'b1, 10'h004, 1'b1, 1'b0, 10'h010, 32'h0, 1'b0);
        chk("after_force_if_stall", {31'b0, if_stall}, 32'h1);
        chk("after_force_d_stall",  {31'b0, d_stall},  32'h0);
        push(1'b1, 32'hDEADBEEF);
`else
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 10'h004, 1'b1, 1'b0, 10'h010, 32'h0, 1'b0);
            chk("strict_if_stall", {31'b0, if_stall}, 32'h1);
            chk("strict_d_stall",  {31'b0, d_stall},  32'h0);
            push(1'b1, 32'hDEADBEEF);
        end
`endif
        drive(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        drive(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);

        // Reset right after a fetch grant: the response is suppressed.
        drive(1'b1, 10'h004, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        chk("pre_rst_stall", {31'b0, if_stall}, 32'h0);
        drive(1'b1, 10'h004, 1'b1, 1'b1, 10'h030, 32'hA5A5A5A5, 1'b1);
        chk("midrst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("midrst_stall",    {30'b0, if_stall, d_stall}, 32'h0);
        chk("midrst_wren",     {31'b0, mem_wren}, 32'h0);
        chk("midrst_addr",     {22'b0, mem_addr}, 32'h0);
        drive(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
            chk("postrst_valid", {30'b0, if_valid, d_valid}, 32'h0);
        end

        @(posedge clk);
        #6;
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
